// File: rtl/ra_4r2w_64x72_ctl.sv
// Request-side controller for the 4R/2W 64x72 DDR array: zero-initialises the array after reset,
// forwards requests, aligns all four read returns and forwards same-cycle write data. Option: RA_BYPASS_CNT_EN.
module ra_4r2w_64x72_ctl #(
    parameter int          RD_LAT   = 2,      // must be >= 2
    parameter logic [71:0] INIT_VAL = 72'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        init_done,
    input  logic        rq_rd_enb_0,
    input  logic        rq_rd_enb_1,
    input  logic        rq_rd_enb_2,
    input  logic        rq_rd_enb_3,
    input  logic [5:0]  rq_rd_adr_0,
    input  logic [5:0]  rq_rd_adr_1,
    input  logic [5:0]  rq_rd_adr_2,
    input  logic [5:0]  rq_rd_adr_3,
    input  logic        rq_wr_enb_0,
    input  logic        rq_wr_enb_1,
    input  logic [5:0]  rq_wr_adr_0,
    input  logic [5:0]  rq_wr_adr_1,
    input  logic [71:0] rq_wr_dat_0,
    input  logic [71:0] rq_wr_dat_1,
    output logic        ra_rd_enb_0,
    output logic        ra_rd_enb_1,
    output logic        ra_rd_enb_2,
    output logic        ra_rd_enb_3,
    output logic [5:0]  ra_rd_adr_0,
    output logic [5:0]  ra_rd_adr_1,
    output logic [5:0]  ra_rd_adr_2,
    output logic [5:0]  ra_rd_adr_3,
    output logic        ra_wr_enb_0,
    output logic        ra_wr_enb_1,
    output logic [5:0]  ra_wr_adr_0,
    output logic [5:0]  ra_wr_adr_1,
    output logic [71:0] ra_wr_dat_0,
    output logic [71:0] ra_wr_dat_1,
    input  logic [71:0] ra_rd_dat_0,
    input  logic [71:0] ra_rd_dat_1,
    input  logic [71:0] ra_rd_dat_2,
    input  logic [71:0] ra_rd_dat_3,
    output logic        rsp_vld_0,
    output logic        rsp_vld_1,
    output logic        rsp_vld_2,
    output logic        rsp_vld_3,
    output logic [71:0] rsp_dat_0,
    output logic [71:0] rsp_dat_1,
    output logic [71:0] rsp_dat_2,
    output logic [71:0] rsp_dat_3
`ifdef RA_BYPASS_CNT_EN
    ,
    output logic [15:0] bypass_cnt
`endif
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_reg;
    logic [4:0]  icnt_reg;
    logic        run;
    logic [3:0]  rd_enb;
    logic [5:0]  rd_adr [4];
    logic [71:0] arr_dat [4];
    logic [1:0]  wr_enb;
    logic [5:0]  wr_adr [2];
    logic [71:0] wr_dat [2];
    logic [3:0]  ra_rd_enb_w;
    logic [5:0]  ra_rd_adr_w [4];
    logic [1:0]  ra_wr_enb_w;
    logic [5:0]  ra_wr_adr_w [2];
    logic [71:0] ra_wr_dat_w [2];
    logic [3:0]  rsp_vld_w;
    logic [71:0] rsp_dat_w [4];

    assign rd_enb  = {rq_rd_enb_3, rq_rd_enb_2, rq_rd_enb_1, rq_rd_enb_0};
    assign rd_adr  = '{rq_rd_adr_0, rq_rd_adr_1, rq_rd_adr_2, rq_rd_adr_3};
    assign arr_dat = '{ra_rd_dat_0, ra_rd_dat_1, ra_rd_dat_2, ra_rd_dat_3};
    assign wr_enb  = {rq_wr_enb_1, rq_wr_enb_0};
    assign wr_adr  = '{rq_wr_adr_0, rq_wr_adr_1};
    assign wr_dat  = '{rq_wr_dat_0, rq_wr_dat_1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_INIT;
            icnt_reg  <= '0;
        end else if (state_reg == ST_INIT) begin
            icnt_reg <= icnt_reg + 5'd1;
            if (icnt_reg == 5'd31) state_reg <= ST_RUN;
        end
    end

    assign run       = (state_reg == ST_RUN);
    assign init_done = run;

    // Array outputs are forced quiet while reset is held, even though the state already reads INIT.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_wr
        assign ra_wr_enb_w[gi] = reset & (~run | wr_enb[gi]);
        assign ra_wr_adr_w[gi] = !reset ? 6'd0 : run ? wr_adr[gi] : {icnt_reg, 1'(gi)};
        assign ra_wr_dat_w[gi] = !reset ? 72'd0 : run ? wr_dat[gi] : INIT_VAL;
    end

    for (gi = 0; gi < 4; gi++) begin : g_port
        logic        acc, hit0, hit1, byp;
        logic [71:0] bdat, arr_late;
        logic        vld_pipe_reg  [RD_LAT];
        logic        byp_pipe_reg  [RD_LAT];
        logic [71:0] bdat_pipe_reg [RD_LAT];
        logic        rsp_vld_reg;
        logic [71:0] rsp_dat_reg;

        assign acc  = run & rd_enb[gi];
        assign hit0 = wr_enb[0] & (wr_adr[0] == rd_adr[gi]);
        assign hit1 = wr_enb[1] & (wr_adr[1] == rd_adr[gi]);
        assign byp  = acc & (hit0 | hit1);
        // Write 1 lands in the array's second half-cycle, so it is the value a colliding read must see.
        assign bdat = hit1 ? wr_dat[1] : wr_dat[0];

        assign ra_rd_enb_w[gi] = reset & acc;
        assign ra_rd_adr_w[gi] = (reset & run) ? rd_adr[gi] : 6'd0;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s < RD_LAT; s++) begin
                    vld_pipe_reg[s]  <= 1'b0;
                    byp_pipe_reg[s]  <= 1'b0;
                    bdat_pipe_reg[s] <= '0;
                end
                rsp_vld_reg <= 1'b0;
                rsp_dat_reg <= '0;
            end else begin
                vld_pipe_reg[0]  <= acc;
                byp_pipe_reg[0]  <= byp;
                bdat_pipe_reg[0] <= bdat;
                for (int s = 1; s < RD_LAT; s++) begin
                    vld_pipe_reg[s]  <= vld_pipe_reg[s-1];
                    byp_pipe_reg[s]  <= byp_pipe_reg[s-1];
                    bdat_pipe_reg[s] <= bdat_pipe_reg[s-1];
                end
                rsp_vld_reg <= vld_pipe_reg[RD_LAT-1];
                if (vld_pipe_reg[RD_LAT-1])
                    rsp_dat_reg <= byp_pipe_reg[RD_LAT-1] ? bdat_pipe_reg[RD_LAT-1] : arr_late;
            end
        end

        // Ports 2/3 return a cycle early; one holding stage realigns them with ports 0/1.
        if (gi < 2) begin : g_direct
            assign arr_late = arr_dat[gi];
        end else begin : g_held
            logic [71:0] hold_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)                        hold_reg <= '0;
                else if (vld_pipe_reg[RD_LAT-2])   hold_reg <= arr_dat[gi];
            end
            assign arr_late = hold_reg;
        end

        assign rsp_vld_w[gi] = rsp_vld_reg;
        assign rsp_dat_w[gi] = rsp_dat_reg;
    end

`ifdef RA_BYPASS_CNT_EN
    logic [15:0] bcnt_reg;
    logic [16:0] bcnt_sum;
    assign bcnt_sum = {1'b0, bcnt_reg} + 17'(g_port[0].byp) + 17'(g_port[1].byp)
                    + 17'(g_port[2].byp) + 17'(g_port[3].byp);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bcnt_reg <= '0;
        else        bcnt_reg <= bcnt_sum[16] ? 16'hFFFF : bcnt_sum[15:0];
    end
    assign bypass_cnt = bcnt_reg;
`endif

    assign ra_rd_enb_0 = ra_rd_enb_w[0];
    assign ra_rd_enb_1 = ra_rd_enb_w[1];
    assign ra_rd_enb_2 = ra_rd_enb_w[2];
    assign ra_rd_enb_3 = ra_rd_enb_w[3];
    assign ra_rd_adr_0 = ra_rd_adr_w[0];
    assign ra_rd_adr_1 = ra_rd_adr_w[1];
    assign ra_rd_adr_2 = ra_rd_adr_w[2];
    assign ra_rd_adr_3 = ra_rd_adr_w[3];
    assign ra_wr_enb_0 = ra_wr_enb_w[0];
    assign ra_wr_enb_1 = ra_wr_enb_w[1];
    assign ra_wr_adr_0 = ra_wr_adr_w[0];
    assign ra_wr_adr_1 = ra_wr_adr_w[1];
    assign ra_wr_dat_0 = ra_wr_dat_w[0];
    assign ra_wr_dat_1 = ra_wr_dat_w[1];
    assign rsp_vld_0   = rsp_vld_w[0];
    assign rsp_vld_1   = rsp_vld_w[1];
    assign rsp_vld_2   = rsp_vld_w[2];
    assign rsp_vld_3   = rsp_vld_w[3];
    assign rsp_dat_0   = rsp_dat_w[0];
    assign rsp_dat_1   = rsp_dat_w[1];
    assign rsp_dat_2   = rsp_dat_w[2];
    assign rsp_dat_3   = rsp_dat_w[3];
endmodule

// File: tb/tb_ra_4r2w_64x72_ctl.sv
// Randomised bench for ra_4r2w_64x72_ctl: a DDR array model feeds the DUT, and a write-first
// memory scoreboard predicts every response, init sequence and forwarded request.
module tb_ra_4r2w_64x72_ctl;
    localparam int          RD_LAT   = 2;
    localparam logic [71:0] INIT_VAL = 72'h0;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, nx_reset;
    logic        rd_enb [4];
    logic [5:0]  rd_adr [4];
    logic        wr_enb [2];
    logic [5:0]  wr_adr [2];
    logic [71:0] wr_dat [2];
    logic [71:0] arr_dat [4];
    logic        init_done;
    logic        ra_rd_enb [4];
    logic [5:0]  ra_rd_adr [4];
    logic        ra_wr_enb [2];
    logic [5:0]  ra_wr_adr [2];
    logic [71:0] ra_wr_dat [2];
    logic        rsp_vld [4];
    logic [71:0] rsp_dat [4];
`ifdef RA_BYPASS_CNT_EN
    logic [15:0] bypass_cnt;
    int          exp_bcnt;
`endif

    ra_4r2w_64x72_ctl #(.RD_LAT(RD_LAT), .INIT_VAL(INIT_VAL)) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .rq_rd_enb_0(rd_enb[0]), .rq_rd_enb_1(rd_enb[1]), .rq_rd_enb_2(rd_enb[2]), .rq_rd_enb_3(rd_enb[3]),
        .rq_rd_adr_0(rd_adr[0]), .rq_rd_adr_1(rd_adr[1]), .rq_rd_adr_2(rd_adr[2]), .rq_rd_adr_3(rd_adr[3]),
        .rq_wr_enb_0(wr_enb[0]), .rq_wr_enb_1(wr_enb[1]),
        .rq_wr_adr_0(wr_adr[0]), .rq_wr_adr_1(wr_adr[1]),
        .rq_wr_dat_0(wr_dat[0]), .rq_wr_dat_1(wr_dat[1]),
        .ra_rd_enb_0(ra_rd_enb[0]), .ra_rd_enb_1(ra_rd_enb[1]), .ra_rd_enb_2(ra_rd_enb[2]), .ra_rd_enb_3(ra_rd_enb[3]),
        .ra_rd_adr_0(ra_rd_adr[0]), .ra_rd_adr_1(ra_rd_adr[1]), .ra_rd_adr_2(ra_rd_adr[2]), .ra_rd_adr_3(ra_rd_adr[3]),
        .ra_wr_enb_0(ra_wr_enb[0]), .ra_wr_enb_1(ra_wr_enb[1]),
        .ra_wr_adr_0(ra_wr_adr[0]), .ra_wr_adr_1(ra_wr_adr[1]),
        .ra_wr_dat_0(ra_wr_dat[0]), .ra_wr_dat_1(ra_wr_dat[1]),
        .ra_rd_dat_0(arr_dat[0]), .ra_rd_dat_1(arr_dat[1]), .ra_rd_dat_2(arr_dat[2]), .ra_rd_dat_3(arr_dat[3]),
        .rsp_vld_0(rsp_vld[0]), .rsp_vld_1(rsp_vld[1]), .rsp_vld_2(rsp_vld[2]), .rsp_vld_3(rsp_vld[3]),
        .rsp_dat_0(rsp_dat[0]), .rsp_dat_1(rsp_dat[1]), .rsp_dat_2(rsp_dat[2]), .rsp_dat_3(rsp_dat[3])
`ifdef RA_BYPASS_CNT_EN
        , .bypass_cnt(bypass_cnt)
`endif
    );

    typedef struct {
        int          due;
        logic [71:0] dat;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          ecnt     = 0;     // clock edges since reset release
    logic [71:0] refmem [64];
    logic [71:0] arrmem [64];
    exp_t        expq [4][$];
    logic [71:0] exp_last [4];
    logic [71:0] due_dat [4][8];
    logic        due_vld [4][8];

    task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [71:0] rnd72();
        return 72'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic idle();
        for (int x = 0; x < 4; x++) begin
            rd_enb[x] = 1'b0;
            rd_adr[x] = 6'($urandom());
        end
        for (int y = 0; y < 2; y++) begin
            wr_enb[y] = 1'b0;
            wr_adr[y] = 6'($urandom());
            wr_dat[y] = rnd72();
        end
    endtask

    // One clock: check registered outputs at negedge, apply reset, check array-side outputs,
    // then advance the scoreboard and the array model just after the posedge.
    task automatic step();
        logic        ev, run_now, init_now;
        logic        sn_rd_enb [4];
        logic [5:0]  sn_rd_adr [4];
        logic        sn_wr_enb [2];
        logic [5:0]  sn_wr_adr [2];
        logic [71:0] sn_wr_dat [2];
        int          slot, nb;
        @(negedge clk);
        for (int x = 0; x < 4; x++) begin
            ev = (expq[x].size() > 0) && (expq[x][0].due == cyc);
            if (ev) begin
                exp_last[x] = expq[x][0].dat;
                void'(expq[x].pop_front());
                $display("cycle %0d response port %0d data %h", cyc, x, exp_last[x]);
            end
            check($sformatf("rsp_vld_%0d", x), 72'(rsp_vld[x]), 72'(ev));
            check($sformatf("rsp_dat_%0d", x), rsp_dat[x], exp_last[x]);
        end
        check("init_done", 72'(init_done), 72'((reset === 1'b1) && (ecnt >= 32)));
`ifdef RA_BYPASS_CNT_EN
        check("bypass_cnt", 72'(bypass_cnt), 72'(exp_bcnt));
`endif
        reset = nx_reset;
        #1;
        if (!reset) begin
            ecnt = 0;
            for (int a = 0; a < 64; a++) refmem[a] = INIT_VAL;
            for (int x = 0; x < 4; x++) begin
                expq[x].delete();
                exp_last[x] = '0;
                check($sformatf("rst_rsp_vld_%0d", x), 72'(rsp_vld[x]), 72'd0);
                check($sformatf("rst_rsp_dat_%0d", x), rsp_dat[x], 72'd0);
            end
            check("rst_init_done", 72'(init_done), 72'd0);
`ifdef RA_BYPASS_CNT_EN
            exp_bcnt = 0;
            check("rst_bypass_cnt", 72'(bypass_cnt), 72'd0);
`endif
        end
        run_now  = reset && (ecnt >= 32);
        init_now = reset && (ecnt < 32);
        for (int x = 0; x < 4; x++) begin
            check($sformatf("ra_rd_enb_%0d", x), 72'(ra_rd_enb[x]), 72'(run_now && rd_enb[x]));
            if (!init_now)
                check($sformatf("ra_rd_adr_%0d", x), 72'(ra_rd_adr[x]), run_now ? 72'(rd_adr[x]) : 72'd0);
            sn_rd_enb[x] = ra_rd_enb[x];
            sn_rd_adr[x] = ra_rd_adr[x];
        end
        for (int y = 0; y < 2; y++) begin
            check($sformatf("ra_wr_enb_%0d", y), 72'(ra_wr_enb[y]), 72'(init_now || (run_now && wr_enb[y])));
            check($sformatf("ra_wr_adr_%0d", y), 72'(ra_wr_adr[y]),
                  init_now ? 72'(2 * ecnt + y) : run_now ? 72'(wr_adr[y]) : 72'd0);
            check($sformatf("ra_wr_dat_%0d", y), ra_wr_dat[y],
                  init_now ? INIT_VAL : run_now ? wr_dat[y] : 72'd0);
            sn_wr_enb[y] = ra_wr_enb[y];
            sn_wr_adr[y] = ra_wr_adr[y];
            sn_wr_dat[y] = ra_wr_dat[y];
        end
        @(posedge clk);
        #1;
        if (run_now) begin
            // Write-first: this cycle's writes are visible to this cycle's reads.
            nb = 0;
            for (int x = 0; x < 4; x++)
                if (rd_enb[x] && ((wr_enb[0] && wr_adr[0] == rd_adr[x]) || (wr_enb[1] && wr_adr[1] == rd_adr[x])))
                    nb++;
            for (int y = 0; y < 2; y++)
                if (wr_enb[y]) refmem[wr_adr[y]] = wr_dat[y];
            for (int x = 0; x < 4; x++)
                if (rd_enb[x]) expq[x].push_back(exp_t'{cyc + RD_LAT + 1, refmem[rd_adr[x]]});
`ifdef RA_BYPASS_CNT_EN
            exp_bcnt = (exp_bcnt + nb > 65535) ? 65535 : exp_bcnt + nb;
`endif
        end
        if (reset) ecnt++;
        // Array model: old data on reads, ports 0/1 valid RD_LAT cycles later, 2/3 one earlier.
        for (int x = 0; x < 4; x++)
            if (sn_rd_enb[x]) begin
                slot = (cyc + ((x < 2) ? RD_LAT - 1 : RD_LAT - 2)) % 8;
                due_dat[x][slot] = arrmem[sn_rd_adr[x]];
                due_vld[x][slot] = 1'b1;
            end
        for (int y = 0; y < 2; y++)
            if (sn_wr_enb[y]) arrmem[sn_wr_adr[y]] = sn_wr_dat[y];
        for (int x = 0; x < 4; x++) begin
            arr_dat[x] = due_vld[x][cyc % 8] ? due_dat[x][cyc % 8] : rnd72();
            due_vld[x][cyc % 8] = 1'b0;
        end
        cyc++;
    endtask

    initial begin
        reset    = 1'b0;
        nx_reset = 1'b0;
`ifdef RA_BYPASS_CNT_EN
        exp_bcnt = 0;
`endif
        for (int a = 0; a < 64; a++) begin
            arrmem[a] = rnd72();
            refmem[a] = INIT_VAL;
        end
        for (int x = 0; x < 4; x++) begin
            exp_last[x] = '0;
            arr_dat[x]  = rnd72();
            for (int s = 0; s < 8; s++) due_vld[x][s] = 1'b0;
        end
        idle();
        repeat (3) step();
        // Initialisation with requests that must be ignored.
        nx_reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            idle();
            rd_enb[0] = 1'b1;
            wr_enb[i % 2] = 1'b1;
            step();
        end
        idle(); rd_enb[3] = 1'b1; rd_adr[3] = 6'd63; step();
        idle(); repeat (4) step();
        wr_enb[0] = 1'b1; wr_adr[0] = 6'd5; wr_dat[0] = 72'hA5; step();
        idle();
        for (int x = 0; x < 4; x++) begin rd_enb[x] = 1'b1; rd_adr[x] = 6'd5; end
        step();
        idle(); repeat (4) step();
        wr_enb[0] = 1'b1; wr_adr[0] = 6'd9; wr_dat[0] = 72'h11;
        wr_enb[1] = 1'b1; wr_adr[1] = 6'd9; wr_dat[1] = 72'h22;
        rd_enb[0] = 1'b1; rd_adr[0] = 6'd9;
        step();
        idle(); repeat (4) step();
        for (int i = 0; i < 10; i++) begin
            idle();
            for (int x = 0; x < 4; x++) begin rd_enb[x] = 1'b1; rd_adr[x] = 6'(x); end
            wr_enb[0] = 1'b1; wr_adr[0] = 6'(i % 4);
            step();
        end
        idle(); repeat (4) step();
        // Reset one cycle after a read: the read must vanish and init must restart.
        for (int x = 0; x < 4; x++) begin rd_enb[x] = 1'b1; rd_adr[x] = 6'($urandom_range(0, 63)); end
        step();
        idle(); nx_reset = 1'b0; repeat (2) step();
        nx_reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            idle();
            for (int x = 0; x < 4; x++) rd_enb[x] = 1'($urandom());
            step();
        end
        for (int i = 0; i < 400; i++) begin
            for (int x = 0; x < 4; x++) begin
                rd_enb[x] = 1'($urandom());
                rd_adr[x] = 6'($urandom_range(0, 7));
            end
            for (int y = 0; y < 2; y++) begin
                wr_enb[y] = 1'($urandom());
                wr_adr[y] = 6'($urandom_range(0, 7));
                wr_dat[y] = rnd72();
            end
            step();
        end
        idle(); repeat (6) step();
        for (int x = 0; x < 4; x++)
            check($sformatf("drained_%0d", x), 72'(expq[x].size()), 72'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ra_4r2w_64x72_ctl.md
Name: ra_4r2w_64x72_ctl

Overview:
- Request-side controller sitting directly upstream of the 4-read/2-write 64x72 DDR array wrapper.
- After reset it zero-initialises all 64 entries. It then forwards read and write requests to the array.
- It aligns read returns from all four ports to one common response cycle.
- It forwards same-cycle write data to colliding reads so the read returns the newly written value (write-first semantics).

Parameters:
- RD_LAT, 2: clocks from request cycle T until ra_rd_dat_0/1 are valid. ra_rd_dat_2/3 are valid one clock earlier, in cycle T+RD_LAT-1. Must be at least 2.
- INIT_VAL, 72'h0: word written to every entry during initialisation.

Ports:
- clk  in  1  array clock.
- reset  in  1  asynchronous, active-low reset.
- init_done  out  1  high once initialisation is complete; requests are accepted only while high.
- rq_rd_enb_x  in  1  read request, port x=0..3.
- rq_rd_adr_x  in  6  read address, x=0..3.
- rq_wr_enb_y  in  1  write request, port y=0..1.
- rq_wr_adr_y  in  6  write address, y=0..1.
- rq_wr_dat_y  in  72  write data, y=0..1.
- ra_rd_enb_x  out  1  to array, x=0..3.
- ra_rd_adr_x  out  6  to array, x=0..3.
- ra_wr_enb_y  out  1  to array, y=0..1.
- ra_wr_adr_y  out  6  to array, y=0..1.
- ra_wr_dat_y  out  72  to array, y=0..1.
- ra_rd_dat_x  in  72  array read data, x=0..3.
- rsp_vld_x  out  1  response valid, x=0..3.
- rsp_dat_x  out  72  response data, x=0..3.

Behaviour:
- State machine: INIT and RUN.
  - Reset asserted forces state INIT, 5-bit init counter icnt=0, and clears every pipeline stage.
- INIT state:
  - ra_wr_enb_0=1, ra_wr_adr_0={icnt,1'b0}.
  - ra_wr_enb_1=1, ra_wr_adr_1={icnt,1'b1}.
  - ra_wr_dat_0/1=INIT_VAL.
  - All ra_rd_enb_x=0.
  - icnt increments each clock. When icnt=31, the next state is RUN. Total 32 clocks, covering all 64 entries.
- init_done:
  - Registered; equals 1 exactly when state=RUN.
  - Reset value 0. Rises on the clock after the icnt=31 cycle.
- RUN state:
  - ra_* outputs are combinational pass-through of the rq_* inputs.
- Requests arriving while init_done=0:
  - Not forwarded to the array.
  - Generate no response and no bypass.
  - Are not queued.
- Response latency:
  - A read accepted in cycle T yields rsp_vld_x=1 for exactly one cycle, T+RD_LAT+1, for all four ports.
  - Per-port valid pipeline depth is RD_LAT.
  - ra_rd_dat_0/1 are registered at the end of cycle T+RD_LAT.
  - ra_rd_dat_2/3 are registered at the end of cycle T+RD_LAT-1, then held one extra stage.
  - Back-to-back reads are fully pipelined with one response per clock per port; there is no backpressure.
- Bypass:
  - Evaluated in the request cycle T for each read port x.
  - Hit condition: rq_rd_enb_x and rq_wr_enb_y and rq_rd_adr_x==rq_wr_adr_y.
  - If both write ports hit, write port 1 wins, matching array DDR order where write 1 occurs in the second half-cycle.
  - A bypass flag and the 72-bit winning write data travel in the read pipeline.
  - At response time, rsp_dat_x = bypass data if the flag is set, else the array data.
  - Writes in earlier cycles are not bypassed; the array already holds them.
- Two writes to the same address in one cycle: forwarded unchanged; the array applies write 1 last.
- Reset values:
  - rsp_vld_x=0, rsp_dat_x=0, init_done=0.
  - ra_*_enb=0 while reset is asserted.
  - ra_*_adr=0 and ra_wr_dat=0 while reset is asserted.
- Reset asserted mid-operation: in-flight reads are dropped with no response. Initialisation restarts from icnt=0 after release.
- rsp_dat_x holds its last value when rsp_vld_x=0.

Optional Feature:
- Macro: RA_BYPASS_CNT_EN.
- When defined:
  - Adds output bypass_cnt, 16 bits.
  - Counts read ports taking a bypass each cycle (0..4 per clock) and saturates at 16'hFFFF.
  - Reset value 0; restarts at 0 after reset.
- When undefined: no port and no logic; the bypass path is otherwise identical.

Test Plan:
- Reset, then release.
  - Expect ra_wr_adr_0/1 = 0/1, 2/3, … 62/63 over 32 clocks.
  - Expect init_done=1 on clock 33.
  - Then read addr 63 on port 3; expect rsp_dat_3=72'h0 at T+3.
- In RUN, write 72'hA5 to addr 5 on wr0 at cycle T. At T+1, read addr 5 on all four ports.
  - Expect all rsp_vld_0..3 at T+4 with data 72'hA5.
- Same cycle: wr0 addr 9 = 72'h11, wr1 addr 9 = 72'h22, rd0 addr 9.
  - Expect rsp_dat_0=72'h22 at T+3.
  - With the macro defined, expect bypass_cnt=1.
- Reads every cycle on ports 0..3 to addresses 0..3 for 10 clocks.
  - Expect a continuous rsp_vld on all ports, with data order matching request order.
- Assert reset at T+1 after a read at T.
  - Expect no rsp_vld and init_done=0.
  - Expect a full 32-clock re-initialisation after release.
- Request rd0 while init_done=0.
  - Expect ra_rd_enb_0 to stay 0 and no response.
